if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller for the RISC-V core.
- Owns the program counter and its chip-enable. Sequences requests to a multi-cycle instruction memory with a one-outstanding-request handshake.
- Applies branch/jump redirects from EX and holds the fetched instruction in a one-entry output slot until IF/ID accepts it.
- Replaces the free-running PC increment with stall- and redirect-aware sequencing.

Parameters:
- ADDR_W, 32, width of PC and instruction addresses (InstAddrBus).
- INST_W, 32, width of instruction data (InstBus).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  IF/ID not ready; output slot cannot be consumed this cycle.
- br_flag_i  in  1  redirect request from EX, single-cycle pulse.
- br_target_i  in  ADDR_W  redirect target address.
- mem_req_o  out  1  fetch request to instruction memory.
- mem_addr_o  out  ADDR_W  fetch address; stable while mem_req_o is high.
- mem_gnt_i  in  1  memory accepted the request this cycle.
- mem_rvalid_i  in  1  read data valid, one cycle, exactly once per grant.
- mem_rdata_i  in  INST_W  read data.
- inst_valid_o  out  1  output slot holds a valid instruction.
- inst_o  out  INST_W  fetched instruction.
- inst_pc_o  out  ADDR_W  address of inst_o.
- pc_o  out  ADDR_W  next address to fetch.
- ce_o  out  1  fetch enabled (0 during and one cycle after reset).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values (cycle with rst=1): state=IDLE, pc_o=RESET_PC, ce_o=0, mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, discard=0. Reset overrides everything, including an in-flight request. A late mem_rvalid_i after reset is ignored because state≠WAIT.
- States:
  - IDLE: ce_o<=1, go to REQ.
  - REQ: mem_req_o=1, mem_addr_o=pc_o. On mem_gnt_i, pc_o<=pc_o+4 (wraps mod 2^ADDR_W) and go to WAIT.
  - WAIT: on mem_rvalid_i, go to WAIT_DONE handling below.
- Issue rule: REQ is entered (and mem_req_o raised) only when the slot is empty, or is being consumed this cycle (inst_valid_o && !stall_i). Otherwise hold in IDLE/WAIT-completion until free; mem_req_o=0 while waiting.
- Response (WAIT & mem_rvalid_i):
  - If discard=0: inst_o<=mem_rdata_i, inst_pc_o<=address of the granted request, inst_valid_o<=1.
  - If discard=1: data is dropped and discard<=0.
  - Then re-evaluate the issue rule.
- Consumption: inst_valid_o && !stall_i clears inst_valid_o, unless a new response is written in the same cycle.
- Redirect (br_flag_i=1), highest priority after rst:
  - pc_o<=br_target_i with bits[1:0] forced to 0.
  - inst_valid_o<=0 (slot flushed, even if stalled).
  - In WAIT, or in REQ with mem_gnt_i in the same cycle: discard<=1, state WAIT.
  - In REQ without grant: request is withdrawn (mem_req_o<=0 for one cycle), then re-issued at the new PC.
  - In IDLE: next REQ uses the target.
- Simultaneous mem_rvalid_i and br_flag_i in WAIT: response dropped, no discard set, next REQ uses the target.
- Latency: first mem_req_o is the 2nd cycle after rst deasserts. With a zero-wait memory (gnt in REQ, rvalid next cycle) and no stall, the sustained rate is one instruction per 2 cycles.
- ce_o stays 1 after IDLE until the next reset.

Decomposition:
- Shared package/defines: InstAddrBus, InstBus widths, RESET_PC, fetch-state encoding (IDLE, REQ, WAIT), and the PC increment constant 4.
- Single module is natural. Optional sub-module if_out_slot for the one-entry instruction/PC holding register with flush.

Test Plan:
- Reset then run, memory gnt immediate and rvalid +1, stall=0 -> mem_addr_o 0x0, 0x4, 0x8 on successive requests; inst_pc_o follows 0x0, 0x4, 0x8; first mem_req_o on 2nd cycle after rst low.
- stall_i=1 for 5 cycles with slot full -> inst_o/inst_pc_o frozen, mem_req_o=0 after the already-issued request completes; on release, next address resumes without a skip.
- br_flag_i with target 0x103 while in WAIT for 0x8 -> rdata for 0x8 discarded (inst_valid_o stays 0), next mem_addr_o=0x100, then inst_pc_o=0x100.
- br_flag_i in the same cycle as mem_rvalid_i -> that instruction never appears; next fetch at the target.
- PC at 0xFFFF_FFFC granted -> next mem_addr_o=0x0000_0000.
- rst asserted mid-WAIT, then late mem_rvalid_i -> ignored; outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, reset PC, PC increment and fetch-state codes for the IF fetch controller.
package if_fetch_ctrl_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          PC_INC       = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle of the IF/ID, EX-redirect and instruction-memory signals seen by the fetch controller.
interface if_fetch_ctrl_if
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int INST_W = INST_BUS
);

  logic              stall_i;
  logic              br_flag_i;
  logic [ADDR_W-1:0] br_target_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [INST_W-1:0] mem_rdata_i;
  logic              inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic [ADDR_W-1:0] pc_o;
  logic              ce_o;

  modport master (
    input  stall_i, br_flag_i, br_target_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, pc_o, ce_o
  );

  modport slave (
    output stall_i, br_flag_i, br_target_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, pc_o, ce_o
  );

endinterface

// File: rtl/if_fetch_ctrl_out_slot.sv
// One-entry holding register for a fetched instruction and its PC; flush drops the entry.
module if_out_slot
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS,
  parameter int INST_W = INST_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              stall,
  input  logic [INST_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc
);

  // A new load wins over consumption so a back-to-back response is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (valid && !stall) begin
        valid <= 1'b0;
      end
      if (load) begin
        inst <= load_inst;
        pc   <= load_pc;
      end
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one outstanding memory request at a time,
// applies EX redirects and feeds a one-entry output slot towards IF/ID.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_ctrl_if.master bus
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              ce;
  logic              discard;
  logic              slot_valid;
  logic [INST_W-1:0] slot_inst;
  logic [ADDR_W-1:0] slot_pc;
  logic              slot_free;
  logic              accept;
  logic              resp;
  logic              slot_load;
  logic [ADDR_W-1:0] br_pc;

  // The request is only shown while the slot will be empty by the time the data can return.
  assign slot_free      = !slot_valid || !bus.stall_i;
  assign bus.mem_req_o  = (state == ST_REQ) && slot_free;
  assign bus.mem_addr_o = (state == ST_REQ) ? pc : '0;
  assign accept         = bus.mem_req_o && bus.mem_gnt_i;
  assign resp           = (state == ST_WAIT) && bus.mem_rvalid_i;
  assign slot_load      = resp && !discard && !bus.br_flag_i;
  assign br_pc          = {bus.br_target_i[ADDR_W-1:2], 2'b00};

  assign bus.pc_o         = pc;
  assign bus.ce_o         = ce;
  assign bus.inst_valid_o = slot_valid;
  assign bus.inst_o       = slot_inst;
  assign bus.inst_pc_o    = slot_pc;

  // Redirect takes priority over normal sequencing; a granted or in-flight fetch is marked for discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      req_pc  <= '0;
      ce      <= 1'b0;
      discard <= 1'b0;
    end else begin
      if (accept) begin
        req_pc <= pc;
      end
      if (bus.br_flag_i) begin
        pc <= br_pc;
        case (state)
          ST_IDLE: begin
            ce    <= 1'b1;
            state <= ST_REQ;
          end
          ST_REQ: begin
            if (accept) begin
              discard <= 1'b1;
              state   <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_WAIT: begin
            if (resp) begin
              discard <= 1'b0;
              state   <= ST_REQ;
            end else begin
              discard <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else begin
        case (state)
          ST_IDLE: begin
            ce    <= 1'b1;
            state <= ST_REQ;
          end
          ST_REQ: begin
            if (accept) begin
              pc    <= pc + ADDR_W'(PC_INC);
              state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (resp) begin
              discard <= 1'b0;
              state   <= ST_REQ;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  if_out_slot #(
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (slot_load),
    .flush    (bus.br_flag_i),
    .stall    (bus.stall_i),
    .load_inst(bus.mem_rdata_i),
    .load_pc  (req_pc),
    .valid    (slot_valid),
    .inst     (slot_inst),
    .pc       (slot_pc)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus a randomized run against a
// stream-level reference model (expected fetch address, live request queue, output slot).
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  if_fetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_fetch_ctrl #(
    .ADDR_W  (32),
    .INST_W  (32),
    .RESET_PC(TB_RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Memory responder state
  logic        pend;
  logic [31:0] pend_addr;
  int          rv_cnt;
  int          lat_min;
  int          lat_max;
  int          gnt_pct;

  // Reference model state
  logic [31:0] exp_addr;
  logic [31:0] live[$];
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_ce;
  logic        armed;
  int          delivered;
  logic        last_req;
  logic        gnt_seen;
  logic [31:0] gnt_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge: compare outputs, then advance the model with this cycle's events.
  task automatic observe_and_model();
    logic acc;
    logic consume;
    logic loaded;
    logic [31:0] a;
    acc      = bus.mem_req_o && bus.mem_gnt_i;
    last_req = bus.mem_req_o;
    if (armed) begin
      check_output("inst_valid", 32'(bus.inst_valid_o), 32'(m_valid));
      if (m_valid) begin
        check_output("inst_pc", bus.inst_pc_o, m_pc);
        check_output("inst", bus.inst_o, mem_word(m_pc));
      end
      check_output("pc", bus.pc_o, exp_addr);
      check_output("ce", 32'(bus.ce_o), 32'(m_ce));
      if (bus.mem_req_o) check_output("mem_addr", bus.mem_addr_o, exp_addr);
      if (pend) check_output("req_outstanding", 32'(bus.mem_req_o), 32'd0);
      if (m_valid && bus.stall_i) check_output("req_full", 32'(bus.mem_req_o), 32'd0);
    end
    if (acc) begin
      pend      = 1'b1;
      pend_addr = bus.mem_addr_o;
      rv_cnt    = $urandom_range(lat_max - 1, lat_min - 1);
    end
    if (rst) begin
      exp_addr = TB_RESET_PC;
      live.delete();
      m_valid  = 1'b0;
      m_pc     = '0;
      m_ce     = 1'b0;
      armed    = 1'b1;
    end else begin
      consume = m_valid && !bus.stall_i;
      loaded  = 1'b0;
      if (consume) delivered++;
      if (bus.mem_rvalid_i && live.size() > 0) begin
        a = live.pop_front();
        if (!bus.br_flag_i) begin
          check_output("slot_overwrite", 32'(m_valid && !consume), 32'd0);
          loaded = 1'b1;
          m_pc   = a;
        end
      end
      if (loaded) m_valid = 1'b1;
      else if (consume) m_valid = 1'b0;
      if (acc) begin
        gnt_seen = 1'b1;
        gnt_addr = bus.mem_addr_o;
        live.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (bus.br_flag_i) begin
        exp_addr = bus.br_target_i & 32'hFFFF_FFFC;
        live.delete();
        m_valid = 1'b0;
      end
      m_ce = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs, sample at the falling edge, return 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic r, input logic st, input logic b, input logic [31:0] tgt);
    rst              = r;
    bus.stall_i      = st;
    bus.br_flag_i    = b;
    bus.br_target_i  = tgt;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = $urandom;
    if (pend) begin
      if (rv_cnt == 0) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = mem_word(pend_addr);
        pend             = 1'b0;
      end else begin
        rv_cnt--;
      end
    end
    bus.mem_gnt_i = !pend && ($urandom_range(99, 0) < gnt_pct);
    @(negedge clk);
    observe_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    gnt_seen = 1'b0;
    while (!gnt_seen && n < budget) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    check_output("grant_timeout", 32'(gnt_seen), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.inst_valid_o && n < budget) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    check_output("valid_timeout", 32'(bus.inst_valid_o), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req"}, 32'(bus.mem_req_o), 32'd0);
    check_output({tag, "_addr"}, bus.mem_addr_o, 32'd0);
    check_output({tag, "_valid"}, 32'(bus.inst_valid_o), 32'd0);
    check_output({tag, "_inst"}, bus.inst_o, 32'd0);
    check_output({tag, "_inst_pc"}, bus.inst_pc_o, 32'd0);
    check_output({tag, "_pc"}, bus.pc_o, TB_RESET_PC);
    check_output({tag, "_ce"}, 32'(bus.ce_o), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int start_delivered;
    pend             = 1'b0;
    pend_addr        = '0;
    rv_cnt           = 0;
    lat_min          = 1;
    lat_max          = 1;
    gnt_pct          = 100;
    armed            = 1'b0;
    delivered        = 0;
    last_req         = 1'b0;
    gnt_seen         = 1'b0;
    gnt_addr         = '0;
    exp_addr         = '0;
    m_valid          = 1'b0;
    m_pc             = '0;
    m_ce             = 1'b0;
    rst              = 1'b1;
    bus.stall_i      = 1'b0;
    bus.br_flag_i    = 1'b0;
    bus.br_target_i  = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;

    $display("[TB] reset");
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_reset_outputs("reset");

    $display("[TB] zero-wait sequential fetch");
    for (int c = 1; c <= 12; c++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      check_output("req_cadence", 32'(last_req), 32'(c % 2 == 0));
    end

    $display("[TB] stall with full slot");
    wait_valid(20);
    held = m_pc;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("stall_inst_pc", bus.inst_pc_o, held);
      check_output("stall_req", 32'(last_req), 32'd0);
    end
    wait_grant(20);
    check_output("resume_addr", gnt_addr, held + 32'd4);

    $display("[TB] redirect while waiting");
    lat_min = 3;
    lat_max = 3;
    wait_grant(20);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    wait_grant(20);
    check_output("redirect_addr", gnt_addr, 32'h0000_0100);
    wait_valid(20);
    check_output("redirect_inst_pc", bus.inst_pc_o, 32'h0000_0100);

    $display("[TB] redirect with simultaneous response");
    lat_min = 1;
    lat_max = 1;
    wait_grant(20);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200);
    wait_grant(20);
    check_output("same_cycle_addr", gnt_addr, 32'h0000_0200);
    wait_valid(20);
    check_output("same_cycle_inst_pc", bus.inst_pc_o, 32'h0000_0200);

    $display("[TB] address wrap");
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    wait_grant(20);
    check_output("wrap_addr0", gnt_addr, 32'hFFFF_FFF8);
    wait_grant(20);
    check_output("wrap_addr1", gnt_addr, 32'hFFFF_FFFC);
    wait_grant(20);
    check_output("wrap_addr2", gnt_addr, 32'h0000_0000);

    $display("[TB] randomized run");
    gnt_pct = 60;
    lat_min = 1;
    lat_max = 3;
    start_delivered = delivered;
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(1'b0, $urandom_range(99, 0) < 30, $urandom_range(99, 0) < 3, $urandom);
    end
    check_output("random_progress", 32'(delivered - start_delivered >= 100), 32'd1);

    $display("[TB] reset during outstanding request");
    gnt_pct = 100;
    lat_min = 3;
    lat_max = 3;
    wait_grant(20);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    check_reset_outputs("midwait_reset");
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    check_output("late_rvalid_valid", 32'(bus.inst_valid_o), 32'd0);
    wait_grant(20);
    check_output("restart_addr", gnt_addr, TB_RESET_PC);
    wait_valid(20);
    check_output("restart_inst_pc", bus.inst_pc_o, TB_RESET_PC);
    check_output("restart_inst", bus.inst_o, mem_word(TB_RESET_PC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
